// File: rtl/decomp_ctrl_pkg.sv
// decomp_ctrl_pkg: FSM states, PC step default and line-buffer entry type.
// Entry fields are sized for the widest supported DATA_W (32); PREFETCH exists only with DECOMP_PREFETCH_EN.
package decomp_ctrl_pkg;
   localparam int MAX_W = 32;
   localparam logic [31:0] DEF_PC_STEP = 32'b100;
   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      DECODE,
      RESP
`ifdef DECOMP_PREFETCH_EN
      , PREFETCH
`endif
   } state_t;
   typedef struct packed {
      logic             valid;
      logic [MAX_W-1:0] tag;
      logic [MAX_W-1:0] data;
   } entry_t;
endpackage

// File: rtl/decomp_line_buf.sv
// decomp_line_buf: direct-mapped tag/data store, one async read port, one fill port, flush clears valids.
module decomp_line_buf
   import decomp_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output entry_t                   rd_entry,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wr_idx,
   input  entry_t                   wr_entry
);
   entry_t mem [DEPTH];
   // flush outranks a same-cycle fill so that fill is dropped
   always_ff @(posedge clk)
      if (reset || flush)
         for (int i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
      else if (we)
         mem[wr_idx] <= wr_entry;
   assign rd_entry = mem[rd_idx];
endmodule

// File: rtl/decomp_fetch_ctrl.sv
// decomp_fetch_ctrl: buffered fetch front end for an instruction decompressor.
// Define DECOMP_PREFETCH_EN to enable idle next-line prefetch.
module decomp_fetch_ctrl
   import decomp_ctrl_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter logic [31:0] PC_STEP   = DEF_PC_STEP,
   parameter int          BUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic [DATA_W-1:0] cpu_pc,
   output logic [DATA_W-1:0] cpu_instr,
   output logic              cpu_valid,
   output logic              dec_req,
   output logic [DATA_W-1:0] dec_pc,
   input  logic              dec_done,
   input  logic [DATA_W-1:0] dec_instr,
   input  logic              flush,
   output logic [15:0]       miss_cnt
);
   localparam int IDX_W = $clog2(BUF_DEPTH);
   state_t state, state_n;
   logic [DATA_W-1:0] req_pc, req_pc_n, dec_pc_n, cpu_instr_n, rd_pc;
   logic dec_req_n, cpu_valid_n, hit, we;
   logic [15:0] miss_n;
   entry_t rd_entry, wr_entry;
`ifdef DECOMP_PREFETCH_EN
   logic seen;
`endif
   // in IDLE the read port probes the next sequential line; otherwise the demand PC
   assign rd_pc = (state == IDLE) ? req_pc + DATA_W'(PC_STEP) : req_pc;
   assign hit = rd_entry.valid && rd_entry.tag == MAX_W'(rd_pc >> (IDX_W + 2));
   assign wr_entry = '{valid: 1'b1, tag: MAX_W'(dec_pc >> (IDX_W + 2)), data: MAX_W'(dec_instr)};
   decomp_line_buf #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .rd_idx   (rd_pc[IDX_W+1:2]),
      .rd_entry (rd_entry),
      .we       (we),
      .wr_idx   (dec_pc[IDX_W+1:2]),
      .wr_entry (wr_entry)
   );
   always_comb begin
      state_n = state;
      req_pc_n = req_pc;
      dec_req_n = dec_req;
      dec_pc_n = dec_pc;
      cpu_instr_n = cpu_instr;
      cpu_valid_n = 1'b0;
      miss_n = miss_cnt;
      we = 1'b0;
      case (state)
         IDLE:
            if (cpu_req && !cpu_valid) begin
               req_pc_n = cpu_pc;
               state_n = LOOKUP;
            end
`ifdef DECOMP_PREFETCH_EN
            else if (!cpu_req && seen && !hit) begin
               dec_req_n = 1'b1;
               dec_pc_n = rd_pc;
               state_n = PREFETCH;
            end
`endif
         LOOKUP:
            if (hit) begin
               cpu_instr_n = rd_entry.data[DATA_W-1:0];
               state_n = RESP;
            end else begin
               dec_req_n = 1'b1;
               dec_pc_n = req_pc;
               miss_n = miss_cnt + 16'(miss_cnt != 16'hFFFF);
               state_n = DECODE;
            end
         DECODE:
            if (dec_done) begin
               we = 1'b1;
               cpu_instr_n = dec_instr;
               dec_req_n = 1'b0;
               state_n = RESP;
            end
         RESP: begin
            cpu_valid_n = 1'b1;
            state_n = IDLE;
         end
`ifdef DECOMP_PREFETCH_EN
         PREFETCH:
            if (dec_done) begin
               we = 1'b1;
               dec_req_n = 1'b0;
               state_n = IDLE;
            end
`endif
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         req_pc <= '0;
         dec_req <= 1'b0;
         dec_pc <= '0;
         cpu_instr <= '0;
         cpu_valid <= 1'b0;
         miss_cnt <= '0;
`ifdef DECOMP_PREFETCH_EN
         seen <= 1'b0;
`endif
      end else begin
         state <= state_n;
         req_pc <= req_pc_n;
         dec_req <= dec_req_n;
         dec_pc <= dec_pc_n;
         cpu_instr <= cpu_instr_n;
         cpu_valid <= cpu_valid_n;
         miss_cnt <= miss_n;
`ifdef DECOMP_PREFETCH_EN
         if (state == LOOKUP) seen <= 1'b1;
`endif
      end
endmodule

// File: doc/decomp_fetch_ctrl.md
DECOMP_FETCH_CTRL -- requirements
Module: decomp_fetch_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction and PC width.
REQ-002 SHALL have parameter PC_STEP, default 32'b100, sequential PC increment.
REQ-003 SHALL have parameter BUF_DEPTH, default 4 (power of 2, >=2), number of decompressed-instruction buffer entries.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 cpu_req  input  1  CPU instruction request; held high with cpu_pc stable until cpu_valid.
REQ-008 cpu_pc  input  DATA_W  requested PC, word aligned.
REQ-009 cpu_instr  output  DATA_W  decompressed instruction, valid while cpu_valid.
REQ-010 cpu_valid  output  1  one-cycle response pulse.
REQ-011 dec_req  output  1  decompressor start; held until dec_done.
REQ-012 dec_pc  output  DATA_W  PC to decompress, stable while dec_req.
REQ-013 dec_done  input  1  one-cycle pulse, dec_instr valid.
REQ-014 dec_instr  input  DATA_W  decompressor result.
REQ-015 flush  input  1  invalidate all buffer entries.
REQ-016 miss_cnt  output  16  saturating count of demand misses.

Function
REQ-017 SHALL index the buffer by cpu_pc[log2(BUF_DEPTH)+1:2]; tag = remaining upper PC bits plus a valid bit.
REQ-018 SHALL implement FSM IDLE, LOOKUP, DECODE, RESP, PREFETCH (PREFETCH only under REQ-032).
REQ-019 IDLE: on cpu_req capture cpu_pc into req_pc, go LOOKUP.
REQ-020 LOOKUP: hit -> RESP with buffered data; miss -> DECODE, dec_req=1, dec_pc=req_pc, miss_cnt+1 (saturate at 0xFFFF).
REQ-021 DECODE: hold dec_req/dec_pc; on dec_done write {tag,dec_instr} to indexed entry, go RESP.
REQ-022 RESP: cpu_valid=1 for exactly one cycle, then IDLE.
REQ-023 Hit latency SHALL be 2 cycles: cpu_req sampled at edge N, cpu_valid high after edge N+2. Miss latency = 2 + decompressor cycles + 1.
REQ-024 Conflict: a fill to an occupied index SHALL overwrite it (direct-mapped eviction).
REQ-025 flush SHALL clear all valid bits at the next edge; a dec_done in the same cycle is still returned to the CPU but NOT written.
REQ-026 flush SHALL NOT abort an in-flight dec_req.
REQ-027 dec_done outside DECODE/PREFETCH SHALL be ignored.
REQ-028 cpu_req while not IDLE SHALL be sampled only on return to IDLE.

Reset
REQ-029 On reset: FSM=IDLE, all valid bits=0, cpu_valid=0, cpu_instr=0, dec_req=0, dec_pc=0, miss_cnt=0.
REQ-030 Reset mid-DECODE SHALL drop the request; a later dec_done is ignored per REQ-027.
REQ-031 Buffer data contents need not be reset; only valid bits.

Configuration
REQ-032 Macro DECOMP_PREFETCH_EN defined: in IDLE with cpu_req=0 and last_pc+PC_STEP not buffered, go PREFETCH, issue dec_req for last_pc+PC_STEP; on dec_done fill entry, return IDLE without cpu_valid; cpu_req arriving in PREFETCH waits per REQ-028; miss_cnt not incremented.
REQ-033 Undefined: no PREFETCH state, dec_req only on demand misses.

Structure
REQ-034 Package decomp_ctrl_pkg SHALL hold the FSM state enum, PC_STEP default and the buffer entry struct {valid, tag, data}.
REQ-035 Sub-module decomp_line_buf SHALL hold tag/data storage with one read port (lookup) and one write port (fill, flush).

Verification
REQ-036 Reset, cpu_req pc=0x000, dec_done 3 cycles after dec_req with 0xE52DB004 -> dec_pc=0x000, cpu_instr=0xE52DB004, miss_cnt=1.
REQ-037 Repeat pc=0x000 -> cpu_valid 2 cycles after req, no dec_req, miss_cnt=1.
REQ-038 pc=0x010 (BUF_DEPTH=4) then pc=0x000 -> both miss, miss_cnt=3.
REQ-039 flush with dec_done in same cycle for pc=0x1BC, data 0x1EFF2FE1 -> cpu_instr=0x1EFF2FE1, next req 0x1BC misses.
REQ-040 Reset asserted in DECODE, stray dec_done afterward -> no cpu_valid, dec_req=0, all outputs at reset values.
REQ-041 With DECOMP_PREFETCH_EN, idle after pc=0x000 -> dec_pc=0x004 prefetch; req pc=0x004 hits in 2 cycles, miss_cnt unchanged.
